// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, one outstanding miss.
// Define ICACHE_STAT_EN to add the hit_cnt/miss_cnt statistics outputs.
module icache #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic        clear,
    input  logic        if_req_flag,
    input  logic [31:0] if_pc,
    output logic        ice_out_flag,
    output logic [31:0] ice_ins,
    output logic        icache_mem_in_flag,
    output logic [31:0] icache_mem_pc,
    input  logic        icache_mem_out_flag,
    input  logic [31:0] icache_mem_ins
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];
    logic                out_q, out_d;
    logic [31:0]         ins_q, ins_d;
    logic                mreq_q, mreq_d;
    logic [31:0]         mpc_q, mpc_d;
    logic                fill_en;

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  lookup_hit;
    logic                  unused_pc_bits;

    assign req_idx        = if_pc[INDEX_BITS+1:2];
    assign req_tag        = if_pc[31:INDEX_BITS+2];
    assign fill_idx       = mpc_q[INDEX_BITS+1:2];
    assign fill_tag       = mpc_q[31:INDEX_BITS+2];
    assign lookup_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_pc_bits = ^if_pc[1:0];

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        out_d   = 1'b0;
        ins_d   = ins_q;
        mreq_d  = mreq_q;
        mpc_d   = mpc_q;
        fill_en = 1'b0;

        // A flush wins over a stall; a response landing with it still fills the line.
        if (clear) begin
            state_d = IDLE;
            mreq_d  = 1'b0;
            fill_en = (state_q == MISS) && icache_mem_out_flag;
        end else if (ready) begin
            case (state_q)
                IDLE: begin
                    if (if_req_flag) begin
                        if (lookup_hit) begin
                            out_d = 1'b1;
                            ins_d = data_mem[req_idx];
                        end else begin
                            mreq_d  = 1'b1;
                            mpc_d   = {if_pc[31:2], 2'b00};
                            state_d = MISS;
                        end
                    end
                end
                MISS: begin
                    if (icache_mem_out_flag) begin
                        fill_en = 1'b1;
                        out_d   = 1'b1;
                        ins_d   = icache_mem_ins;
                        mreq_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            out_q   <= 1'b0;
            ins_q   <= '0;
            mreq_q  <= 1'b0;
            mpc_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            ins_q   <= ins_d;
            mreq_q  <= mreq_d;
            mpc_q   <= mpc_d;
        end
    end

    // NOTE: tag/data arrays carry no reset; valid_q alone qualifies them, keeping them RAM-mappable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= icache_mem_ins;
        end
    end

    assign ice_out_flag       = out_q;
    assign ice_ins            = ins_q;
    assign icache_mem_in_flag = mreq_q;
    assign icache_mem_pc      = mpc_q;

`ifdef ICACHE_STAT_EN
    logic        hit_ev, miss_ev;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    assign hit_ev  = ready && !clear && (state_q == IDLE) && if_req_flag && lookup_hit;
    assign miss_ev = ready && !clear && (state_q == IDLE) && if_req_flag && !lookup_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_ev) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_ev) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level cache model.
module tb_icache;
    localparam int INDEX_BITS = 8;
    localparam int LINES      = 1 << INDEX_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ready = 1'b0;
    logic        clear = 1'b0;
    logic        if_req_flag = 1'b0;
    logic [31:0] if_pc = '0;
    logic        icache_mem_out_flag = 1'b0;
    logic [31:0] icache_mem_ins = '0;
    logic        ice_out_flag;
    logic [31:0] ice_ins;
    logic        icache_mem_in_flag;
    logic [31:0] icache_mem_pc;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ready               (ready),
        .clear               (clear),
        .if_req_flag         (if_req_flag),
        .if_pc               (if_pc),
        .ice_out_flag        (ice_out_flag),
        .ice_ins             (ice_ins),
        .icache_mem_in_flag  (icache_mem_in_flag),
        .icache_mem_pc       (icache_mem_pc),
        .icache_mem_out_flag (icache_mem_out_flag),
        .icache_mem_ins      (icache_mem_ins)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt             (hit_cnt),
        .miss_cnt            (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory seen by the memory controller.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (pc == 32'h0000_0004) return 32'h0010_0093;
        return (pc * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_valid   [LINES];
    logic [31:0] m_line_pc [LINES];
    logic [31:0] m_line_dat[LINES];
    bit          m_busy;
    bit          e_out;
    logic [31:0] e_ins, e_mpc, e_hit, e_miss;

    function automatic int line_of(input logic [31:0] pc);
        return int'((pc >> 2) % LINES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0;
        e_out  = 1'b0;
        e_ins  = '0;
        e_mpc  = '0;
        e_hit  = '0;
        e_miss = '0;
    endtask

    task automatic model_install(input logic [31:0] pc, input logic [31:0] data);
        int i;
        i = line_of(pc);
        m_valid[i]    = 1'b1;
        m_line_pc[i]  = pc;
        m_line_dat[i] = data;
    endtask

    task automatic model_step();
        logic [31:0] a;
        int i;
        e_out = 1'b0;
        if (clear) begin
            if (m_busy && icache_mem_out_flag) model_install(e_mpc, icache_mem_ins);
            m_busy = 1'b0;
        end else if (ready) begin
            if (m_busy) begin
                if (icache_mem_out_flag) begin
                    model_install(e_mpc, icache_mem_ins);
                    m_busy = 1'b0;
                    e_out  = 1'b1;
                    e_ins  = icache_mem_ins;
                end
            end else if (if_req_flag) begin
                a = if_pc & 32'hFFFF_FFFC;
                i = line_of(a);
                if (m_valid[i] && m_line_pc[i] == a) begin
                    e_out = 1'b1;
                    e_ins = m_line_dat[i];
                    e_hit = e_hit + 32'd1;
                end else begin
                    m_busy = 1'b1;
                    e_mpc  = a;
                    e_miss = e_miss + 32'd1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare and event counters ----------------
    bit   cmp_en = 1'b0;
    int   n_out = 0;
    int   n_inrise = 0;
    logic prev_in = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (ice_out_flag === 1'b1) n_out++;
            if (icache_mem_in_flag === 1'b1 && !prev_in) n_inrise++;
            prev_in = icache_mem_in_flag;
            if (cmp_en) begin
                check("model ice_out_flag", ice_out_flag, e_out);
                check("model ice_ins", ice_ins, e_ins);
                check("model mem_in_flag", icache_mem_in_flag, m_busy);
                check("model mem_pc", icache_mem_pc, e_mpc);
`ifdef ICACHE_STAT_EN
                check("model hit_cnt", hit_cnt, e_hit);
                check("model miss_cnt", miss_cnt, e_miss);
`endif
            end
        end
    end

    // ---------------- stimulus: CPU fetch side + memory controller ----------------
    int lat = 3;
    int mc_wait = 0;
    bit spur_en = 1'b0;

    task automatic tick();
        icache_mem_out_flag = 1'b0;
        if (icache_mem_in_flag) begin
            if (mc_wait >= lat && ready) begin
                icache_mem_out_flag = 1'b1;
                icache_mem_ins      = mem_word(icache_mem_pc);
                mc_wait             = 0;
            end else begin
                mc_wait++;
            end
        end else begin
            mc_wait = 0;
            if (spur_en && $urandom_range(0, 31) == 0) begin
                icache_mem_out_flag = 1'b1;
                icache_mem_ins      = $urandom;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic raw_edge();
        @(posedge clk);
        #1;
        icache_mem_out_flag = 1'b0;
        clear               = 1'b0;
    endtask

    task automatic wait_out(input int budget, output bit got);
        int n;
        n = 0;
        while (!ice_out_flag && n < budget) begin
            tick();
            n++;
        end
        got = ice_out_flag;
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << (INDEX_BITS + 2)) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        bit got;
        int n0, r0, stall;

        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ice_out_flag", ice_out_flag, 1'b0);
        check("reset ice_ins", ice_ins, 32'h0);
        check("reset mem_in_flag", icache_mem_in_flag, 1'b0);
        check("reset mem_pc", icache_mem_pc, 32'h0);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Cold fetch of 0x4, memory answers after 6 cycles.
        lat = 6; n0 = n_out; r0 = n_inrise;
        if_pc = 32'h4; if_req_flag = 1'b1;
        tick();
        check("cold miss in_flag", icache_mem_in_flag, 1'b1);
        check("cold miss mem_pc", icache_mem_pc, 32'h4);
        check("cold miss no out", ice_out_flag, 1'b0);
        wait_out(30, got);
        check("cold served", got, 1'b1);
        check("cold ins", ice_ins, 32'h0010_0093);
        if_req_flag = 1'b0;
        repeat (3) tick();
        check("cold one out pulse", n_out - n0, 1);
        check("cold one mem request", n_inrise - r0, 1);
`ifdef ICACHE_STAT_EN
        check("cold miss_cnt", miss_cnt, 32'd1);
`endif

        // Refetch of 0x4 hits with one-cycle latency.
        if_pc = 32'h4; if_req_flag = 1'b1;
        tick();
        check("refetch out_flag", ice_out_flag, 1'b1);
        check("refetch ins", ice_ins, 32'h0010_0093);
        check("refetch no mem req", icache_mem_in_flag, 1'b0);
        if_req_flag = 1'b0;
        tick();
`ifdef ICACHE_STAT_EN
        check("refetch hit_cnt", hit_cnt, 32'd1);
`endif

        // Same index, different tag: 0x404 replaces 0x4, then 0x4 misses again.
        lat = 2;
        if_pc = 32'h404; if_req_flag = 1'b1;
        tick();
        check("conflict miss in_flag", icache_mem_in_flag, 1'b1);
        check("conflict miss mem_pc", icache_mem_pc, 32'h404);
        wait_out(30, got);
        check("conflict served", got, 1'b1);
        check("conflict ins", ice_ins, mem_word(32'h404));
        if_req_flag = 1'b0;
        tick();
        if_pc = 32'h4; if_req_flag = 1'b1;
        tick();
        check("evicted refetch misses", icache_mem_in_flag, 1'b1);
        check("evicted refetch no out", ice_out_flag, 1'b0);
        wait_out(30, got);
        check("evicted refetch ins", ice_ins, 32'h0010_0093);
        if_req_flag = 1'b0;
        tick();

        // Clear two cycles into a miss abandons it.
        lat = 20;
        if_pc = 32'h8; if_req_flag = 1'b1;
        tick();
        tick();
        clear = 1'b1; if_req_flag = 1'b0;
        tick();
        clear = 1'b0;
        check("clear drops in_flag", icache_mem_in_flag, 1'b0);
        check("clear no out", ice_out_flag, 1'b0);
        n0 = n_out;
        repeat (4) tick();
        check("clear no late out", n_out - n0, 0);
        lat = 2;
        if_pc = 32'h8; if_req_flag = 1'b1;
        tick();
        check("after clear misses", icache_mem_in_flag, 1'b1);
        wait_out(30, got);
        check("after clear ins", ice_ins, mem_word(32'h8));
        if_req_flag = 1'b0;
        tick();

        // ready low for 3 cycles during a miss.
        lat = 2;
        if_pc = 32'hC; if_req_flag = 1'b1;
        tick();
        n0 = n_out;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall in_flag held", icache_mem_in_flag, 1'b1);
            check("stall mem_pc held", icache_mem_pc, 32'hC);
            check("stall no out", ice_out_flag, 1'b0);
        end
        ready = 1'b1;
        wait_out(30, got);
        check("stall served", got, 1'b1);
        check("stall ins", ice_ins, mem_word(32'hC));
        if_req_flag = 1'b0;
        repeat (3) tick();
        check("stall one out pulse", n_out - n0, 1);

        // Clear coinciding with the response: line filled, nothing returned.
        lat = 1000;
        if_pc = 32'h10; if_req_flag = 1'b1;
        tick();
        clear = 1'b1; if_req_flag = 1'b0;
        icache_mem_out_flag = 1'b1; icache_mem_ins = mem_word(32'h10);
        raw_edge();
        check("clear+resp no out", ice_out_flag, 1'b0);
        check("clear+resp in_flag", icache_mem_in_flag, 1'b0);
        if_pc = 32'h10; if_req_flag = 1'b1;
        tick();
        check("clear+resp line hit", ice_out_flag, 1'b1);
        check("clear+resp line data", ice_ins, mem_word(32'h10));
        if_req_flag = 1'b0;
        tick();

        // Response while idle is ignored.
        icache_mem_out_flag = 1'b1; icache_mem_ins = 32'hDEAD_BEEF;
        raw_edge();
        check("idle resp no out", ice_out_flag, 1'b0);
        if_pc = 32'h10; if_req_flag = 1'b1;
        tick();
        check("idle resp no refill", ice_ins, mem_word(32'h10));
        if_req_flag = 1'b0;
        tick();

        // Reset during a miss.
        if_pc = 32'h14; if_req_flag = 1'b1;
        tick();
        tick();
        reset = 1'b0; if_req_flag = 1'b0;
        #1;
        check("mid reset out", ice_out_flag, 1'b0);
        check("mid reset ins", ice_ins, 32'h0);
        check("mid reset in_flag", icache_mem_in_flag, 1'b0);
        check("mid reset mem_pc", icache_mem_pc, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        icache_mem_out_flag = 1'b1; icache_mem_ins = mem_word(32'h14);
        raw_edge();
        check("late resp ignored", ice_out_flag, 1'b0);
        lat = 2;
        if_pc = 32'h10; if_req_flag = 1'b1;
        tick();
        check("post reset misses", icache_mem_in_flag, 1'b1);
        wait_out(30, got);
        check("post reset ins", ice_ins, mem_word(32'h10));
        if_req_flag = 1'b0;
        tick();

        // Randomized traffic; the compare process checks every cycle.
        spur_en = 1'b1;
        stall   = 0;
        for (int c = 0; c < 4000; c++) begin
            if (if_req_flag && ice_out_flag) if_req_flag = 1'b0;
            clear = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                clear = 1'b1;
                if_req_flag = 1'b0;
            end else if (!if_req_flag && $urandom_range(0, 1) == 1) begin
                if_pc = rand_pc();
                if_req_flag = 1'b1;
                lat = $urandom_range(0, 5);
            end
            ready = ($urandom_range(0, 7) != 0);
            stall = if_req_flag ? stall + 1 : 0;
            if (stall > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL request not served within budget: pc 0x%08h", if_pc);
                break;
            end
            tick();
        end
        clear = 1'b0; if_req_flag = 1'b0; ready = 1'b1; spur_en = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
